// File: rtl/idx_grant_pkg.sv
// Shared types and helpers for the index-to-grant decoder.
package idx_grant_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } grant_state_t;

    // Widest grant vector the decode helper can build; callers truncate to N.
    localparam int unsigned MAX_N = 64;

    function automatic logic [MAX_N-1:0] onehot_dec(input int unsigned idx, input int unsigned n);
        logic [MAX_N-1:0] r;
        r = '0;
        if (idx < n && idx < MAX_N) begin
            r = MAX_N'(1) << idx;
        end
        return r;
    endfunction

endpackage

// File: rtl/idx_grant_decoder_hold_timer.sv
// Saturating hold counter for an active grant; flags the cycle on which the
// grant must be force-dropped.
module hold_timer #(
    parameter int MAX_HOLD = 16,
    parameter int HOLDW    = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic             rel_i,
    output logic [HOLDW-1:0] cnt_o,
    output logic             tmo_o
);

    localparam bit             TMO_EN = (MAX_HOLD > 0);
    localparam logic [HOLDW-1:0] SAT   = TMO_EN ? HOLDW'(MAX_HOLD) : '1;
    localparam logic [HOLDW-1:0] LIMIT = TMO_EN ? HOLDW'(MAX_HOLD - 1) : '0;

    logic [HOLDW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && cnt_q != SAT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A release in the same cycle wins over the timeout.
    assign tmo_o = TMO_EN && inc_i && !rel_i && (cnt_q == LIMIT);
    assign cnt_o = cnt_q;

endmodule

// File: rtl/idx_grant_decoder.sv
// Accepts an encoded winner index and holds a registered one-hot grant until
// the owner releases it or the hold timer expires.
module idx_grant_decoder
    import idx_grant_pkg::*;
#(
    parameter int N        = 8,
    parameter int IDXW     = $clog2(N),
    parameter int MAX_HOLD = 16,
    parameter int HOLDW    = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             idx_valid_i,
    output logic             idx_ready_o,
    input  logic [IDXW-1:0]  idx_i,
    input  logic [N-1:0]     release_i,
    output logic [N-1:0]     grant_o,
    output logic             grant_valid_o,
    output logic [IDXW-1:0]  grant_idx_o,
    output logic [HOLDW-1:0] hold_cnt_o,
    output logic             timeout_o,
    output logic             bad_idx_o,
    input  logic             bad_clr_i
);

    grant_state_t    state_q;
    logic [N-1:0]    grant_q, grant_d;
    logic [IDXW-1:0] grant_idx_q;
    logic            timeout_q;
    logic            bad_q;

    logic rel_bit, tmo_now, rel_now, accept, in_range, in_grant;

    // The grant is one-hot, so masking by it selects release[grant_idx].
    assign rel_bit  = |(release_i & grant_q);
    assign in_grant = (state_q == GRANT);
    assign rel_now  = rel_bit | tmo_now;

    assign idx_ready_o = (state_q == IDLE) | (in_grant & rel_now);
    assign accept      = idx_valid_i & idx_ready_o;
    assign in_range    = int'(idx_i) < N;
    assign grant_d     = N'(onehot_dec(int'(idx_i), N));

    hold_timer #(
        .MAX_HOLD (MAX_HOLD),
        .HOLDW    (HOLDW)
    ) u_hold_timer (
        .clk   (clk),
        .rst   (rst),
        .clr_i (~in_grant | rel_now),
        .inc_i (in_grant),
        .rel_i (rel_bit),
        .cnt_o (hold_cnt_o),
        .tmo_o (tmo_now)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            timeout_q   <= 1'b0;
            bad_q       <= 1'b0;
        end else begin
            timeout_q <= tmo_now;

            if (bad_clr_i) begin
                bad_q <= 1'b0;
            end
            if (accept && !in_range) begin
                bad_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (accept && in_range) begin
                        grant_q     <= grant_d;
                        grant_idx_q <= idx_i;
                        state_q     <= GRANT;
                    end
                end
                GRANT: begin
                    if (rel_now) begin
                        if (accept && in_range) begin
                            grant_q     <= grant_d;
                            grant_idx_q <= idx_i;
                        end else begin
                            grant_q <= '0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    grant_q <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign grant_o       = grant_q;
    assign grant_valid_o = |grant_q;
    assign grant_idx_o   = grant_idx_q;
    assign timeout_o     = timeout_q;
    assign bad_idx_o     = bad_q;

endmodule
